// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory path.
//   - access size encodings carried on req_size
//   - load/store unit FSM state encoding
//   - store-data merge helper for read-modify-write of sub-word stores
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    STORE  = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  // Overlay right-aligned store data onto the word read back from memory,
  // so a 4-byte memory write only changes the bytes the store targets.
  function automatic logic [31:0] merge_store(input logic [1:0]  size,
                                              input logic [31:0] old_word,
                                              input logic [31:0] wdata);
    case (size)
      SZ_BYTE: merge_store = {old_word[31:8], wdata[7:0]};
      SZ_HALF: merge_store = {old_word[31:16], wdata[15:0]};
      default: merge_store = wdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extraction and extension.
// Ports:
//   word  in  32  raw memory word, byte at the access address in [7:0]
//   size  in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sign  in  1   sign-extend (1) or zero-extend (0); ignored for words
//   data  out 32  extended result
module lsu_extend
  import cpu_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  always_comb begin
    data = word;
    case (size)
      SZ_BYTE: data = {{24{sign & word[7]}},  word[7:0]};
      SZ_HALF: data = {{16{sign & word[15]}}, word[15:0]};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator-side front end for a byte-addressed data memory.
// Accepts one byte/half/word request at a time over valid/ready, drives the
// memory port, and returns extended load data or a completion/error response.
// Sub-word stores are done as read-modify-write because the memory always
// writes four bytes starting at mem_address.
//
// Optional feature: define LSU_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with rsp_error; otherwise unaligned accesses are legal.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_write/size/signed/addr/wdata  request fields
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata, rsp_error              response payload
//   mem_address/write_en/write_data   memory drive
//   mem_read_data                     combinational memory read data
module load_store_unit
  import cpu_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // Highest legal start address: the access touches addr..addr+3.
  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

  lsu_state_e  state, state_nx;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_wdata;
  logic [31:0] merge_buf;
  logic [31:0] ext_data;
  logic        misalign;
  logic        req_err;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = (req_size == SZ_RSVD) || (req_addr > ADDR_MAX) || misalign;

  lsu_extend u_ext (
    .word (mem_read_data),
    .size (lat_size),
    .sign (lat_signed),
    .data (ext_data)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                 state_nx = RESP;
          else if (!req_write)         state_nx = LOAD;
          else if (req_size == SZ_WORD) state_nx = STORE;
          else                         state_nx = RMW_RD;
        end
      end
      LOAD:    state_nx = RESP;
      RMW_RD:  state_nx = STORE;
      STORE:   state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Write enable and data decode straight from state so that an async reset
  // drops them in the same instant, with no registered write left pending.
  always_comb begin
    req_ready      = (state == IDLE);
    rsp_valid      = (state == RESP);
    mem_write_en   = (state == STORE);
    mem_write_data = 32'd0;
    if (state == STORE)
      mem_write_data = merge_store(lat_size, merge_buf, lat_wdata);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_size    <= SZ_BYTE;
      lat_signed  <= 1'b0;
      lat_wdata   <= 32'd0;
      merge_buf   <= 32'd0;
      rsp_rdata   <= 32'd0;
      rsp_error   <= 1'b0;
      mem_address <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_wdata  <= req_wdata;
            rsp_rdata  <= 32'd0;
            rsp_error  <= req_err;
            // Rejected requests never reach memory, so the address bus
            // keeps whatever it last presented.
            if (!req_err) mem_address <= req_addr;
          end
        end
        LOAD:   rsp_rdata <= ext_data;
        RMW_RD: merge_buf <= mem_read_data;
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-array memory model on the
// memory port, a table of request vectors with expected responses, and a
// scoreboard queue of expectations popped when each response arrives.
module tb_load_store_unit;

  localparam int unsigned MEM_BYTES = 800;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_en;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .mem_address    (mem_address),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Memory model: combinational read, 4-byte write on posedge.
  logic [7:0] mem [0:MEM_BYTES-1];
  logic [9:0] ra;
  assign ra = (mem_address <= 32'(MEM_BYTES - 4)) ? mem_address[9:0] : 10'd0;
  assign mem_read_data = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[ra]         <= mem_write_data[7:0];
      mem[ra + 10'd1] <= mem_write_data[15:8];
      mem[ra + 10'd2] <= mem_write_data[23:16];
      mem[ra + 10'd3] <= mem_write_data[31:24];
    end
  end

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
    int          hold;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic wr, logic [1:0] sz, logic sg, logic [31:0] a,
                              logic [31:0] d, logic [31:0] er, logic ee,
                              int lat, int nw, int hold);
    vec_t v;
    v.wr = wr; v.sz = sz; v.sg = sg; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_wr = nw; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Called #1 after a posedge with the unit in IDLE.
  task automatic run(input string name, input vec_t v);
    vec_t        e;
    int          cyc;
    int          wr;
    logic [31:0] held;
    req_write = v.wr; req_size = v.sz; req_signed = v.sg;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    chk({name, " req_ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(v);
    cyc = 1; wr = 0;
    while (!rsp_valid && cyc < 12) begin
      if (mem_write_en) wr++;
      @(posedge clk); #1;
      cyc++;
    end
    e = exp_q.pop_front();
    chk({name, " rsp_valid_seen"}, 32'(rsp_valid), 32'd1);
    chk({name, " latency"}, 32'(cyc), 32'(e.exp_lat));
    chk({name, " write_pulses"}, 32'(wr), 32'(e.exp_wr));
    chk({name, " rdata"}, rsp_rdata, e.exp_rdata);
    chk({name, " error"}, 32'(rsp_error), 32'(e.exp_err));
    chk({name, " req_ready_resp"}, 32'(req_ready), 32'd0);
    held = rsp_rdata;
    for (int h = 0; h < e.hold; h++) begin
      // A competing request while stalled must be ignored.
      req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10;
      req_wdata = 32'h12345678; req_valid = 1'b1;
      @(posedge clk); #1;
      chk({name, " hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, " hold_rdata"}, rsp_rdata, held);
      chk({name, " hold_ready"}, 32'(req_ready), 32'd0);
      chk({name, " hold_no_write"}, 32'(mem_write_en), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, " rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({name, " back_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

    //        wr  sz     sg  addr    wdata          exp_rdata      err  lat nw hold
    tbl.push_back(mk(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0,   2, 1, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0,   2, 0, 5));
    tbl.push_back(mk(0, 2'b10, 0, 32'h11,  32'h0, ALIGN ? 32'h0 : 32'h00DEADBE, ALIGN, ALIGN ? 1 : 2, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0,   2, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h20,  32'h11223344, 32'h0,        0,   2, 1, 0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h20,  32'hFFFFFFAA, 32'h0,        0,   3, 1, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h20,  32'h0,        32'h112233AA, 0,   2, 0, 0));
    tbl.push_back(mk(0, 2'b00, 1, 32'h20,  32'h0,        32'hFFFFFFAA, 0,   2, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h20,  32'h0,        32'h000000AA, 0,   2, 0, 0));
    tbl.push_back(mk(1, 2'b00, 0, 32'h21,  32'h00000055, 32'h0,        0,   3, 1, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h20,  32'h0,        32'h112255AA, 0,   2, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'h30,  32'hFFFFFFFF, 32'h0,        0,   2, 1, 0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h30,  32'h00008001, 32'h0,        0,   3, 1, 0));
    tbl.push_back(mk(0, 2'b01, 1, 32'h30,  32'h0,        32'hFFFF8001, 0,   2, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h30,  32'h0,        32'hFFFF8001, 0,   2, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0, 32'h30,  32'h0,        32'h00008001, 0,   2, 0, 0));
    tbl.push_back(mk(1, 2'b01, 0, 32'h31,  32'h00001234, 32'h0, ALIGN, ALIGN ? 1 : 3, ALIGN ? 0 : 1, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h30,  32'h0, ALIGN ? 32'hFFFF8001 : 32'hFF123401, 0, 2, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'd797, 32'h0,        32'h0,        1,   1, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'd800, 32'h55555555, 32'h0,        1,   1, 0, 0));
    tbl.push_back(mk(1, 2'b10, 0, 32'd796, 32'hCAFEF00D, 32'h0,        0,   2, 1, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'd796, 32'h0,        32'hCAFEF00D, 0,   2, 0, 0));
    tbl.push_back(mk(0, 2'b11, 0, 32'h0,   32'h0,        32'h0,        1,   1, 0, 0));
    tbl.push_back(mk(1, 2'b11, 0, 32'h20,  32'h0,        32'h0,        1,   1, 0, 0));
    tbl.push_back(mk(0, 2'b10, 0, 32'h20,  32'h0,        32'h112255AA, 0,   2, 0, 0));

    #12;
    chk("reset req_ready",  32'(req_ready), 32'd1);
    chk("reset rsp_valid",  32'(rsp_valid), 32'd0);
    chk("reset rsp_error",  32'(rsp_error), 32'd0);
    chk("reset rsp_rdata",  rsp_rdata, 32'd0);
    chk("reset mem_addr",   mem_address, 32'd0);
    chk("reset mem_we",     32'(mem_write_en), 32'd0);
    chk("reset mem_wdata",  mem_write_data, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) run($sformatf("v%0d", i), tbl[i]);

    // Reset in the read phase of a byte store must abort without writing.
    run("rst_setup", mk(1, 2'b10, 0, 32'h40, 32'h01020304, 32'h0, 0, 2, 1, 0));
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h000000EE; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_rd addr", mem_address, 32'h40);
    chk("rmw_rd no_write", 32'(mem_write_en), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rst req_ready",  32'(req_ready), 32'd1);
    chk("rst rsp_valid",  32'(rsp_valid), 32'd0);
    chk("rst mem_we",     32'(mem_write_en), 32'd0);
    chk("rst mem_addr",   mem_address, 32'd0);
    chk("rst mem_wdata",  mem_write_data, 32'd0);
    @(posedge clk); #1;
    chk("rst held mem_we", 32'(mem_write_en), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst rsp_valid", 32'(rsp_valid), 32'd0);
    run("rst_check", mk(0, 2'b10, 0, 32'h40, 32'h0, 32'h01020304, 0, 2, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side front end for the byte-addressed data memory.
- Accepts byte, halfword and word load/store requests from the CPU core over a valid/ready handshake. Drives the memory's address, write-enable and write-data port, and returns sign- or zero-extended load data or a completion/error response.
- Sub-word stores use read-modify-write, because the memory always writes 4 bytes at address..address+3.
- Memory packing: byte at address A is mem_read_data[7:0]; A+3 is [31:24].

Parameters:
- MEM_BYTES, 800: memory size in bytes. Legal access iff req_addr <= MEM_BYTES-4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  request rejected; memory untouched.
- mem_address  out  32  to memory address.
- mem_write_en  out  1  to memory write enable.
- mem_write_data  out  32  to memory write data.
- mem_read_data  in  32  combinational read data from memory.

Behaviour:
- Reset (async, reset_n low), any state: state=IDLE.
  - req_ready=1, rsp_valid=0, rsp_error=0.
  - rsp_rdata=0, mem_address=0, mem_write_en=0, mem_write_data=0.
  - An in-flight request is dropped with no response. mem_write_en falls immediately, so no write can occur.
- mem_write_en is high only in STORE. mem_address drives the latched address in LOAD, RMW_RD and STORE, and holds its last value otherwise.
- IDLE: req_ready=1. On req_valid, latch write/size/signed/addr/wdata, then check:
  - error if req_size=11, or req_addr > MEM_BYTES-4, or misalignment (see Optional Feature);
  - error -> RESP with rsp_error=1;
  - otherwise load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
- LOAD (1 cycle): capture mem_read_data.
  - Extract [7:0] or [15:0] or [31:0] and extend per req_signed (word ignores signed).
  - Register into rsp_rdata; -> RESP.
- RMW_RD (1 cycle): capture mem_read_data into merge buffer; -> STORE.
- STORE (1 cycle): mem_write_en=1; -> RESP. mem_write_data is:
  - word: wdata;
  - half: {buf[31:16], wdata[15:0]};
  - byte: {buf[31:8], wdata[7:0]}.
- RESP: rsp_valid=1, outputs stable until rsp_ready sampled high; then -> IDLE with rsp_valid=0. req_ready=0 throughout RESP.
- Latency, accept edge to first rsp_valid edge:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: at most one outstanding request. A new request can be accepted no earlier than the cycle after the response handshake.
- rsp_ready high while not in RESP is ignored.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro LSU_ALIGN_CHECK_EN.
  - Defined: half with addr[0]=1, or word with addr[1:0]!=0, gives rsp_error=1 and no memory access.
  - Undefined: unaligned accesses are legal; only size and range checks apply.

Decomposition:
- Shared package cpu_mem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - LSU state encoding IDLE/LOAD/RMW_RD/STORE/RESP.
- Sub-module lsu_extend: combinational size/sign extraction from a 32-bit word. Used in LOAD.

Test Plan:
- Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> load response rsp_rdata=0xDEADBEEF, rsp_error=0; store response after 2 cycles with exactly one mem_write_en pulse.
- Word at 0x20 = 0x11223344, byte store 0xAA to 0x20, word load 0x20 -> 0x112233AA. Signed byte load 0x20 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
- Half store 0x8001 to 0x30 over 0xFFFFFFFF, signed half load 0x30 -> 0xFFFF8001; word load -> 0xFFFF8001.
- Out-of-range word load at 797 (MEM_BYTES=800) -> rsp_error=1 after 1 cycle, mem_write_en never high. Load at 796 succeeds. req_size=11 -> error.
- Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0. Release -> IDLE next cycle.
- Assert reset_n low during RMW_RD of a byte store -> immediate IDLE outputs, target word unchanged. With LSU_ALIGN_CHECK_EN, word load at 0x11 -> rsp_error=1; without it -> data returned.
